// File: rtl/switch_debounce2.sv
// switch_debounce2: two independent switch conditioners.
// Each channel synchronizes a raw asynchronous level, qualifies it over a
// window of 2^CNT_WIDTH consecutive disagreeing cycles, and reports the
// committed level together with registered one-cycle rise/fall pulses.
module switch_debounce2 #(
    parameter int CNT_WIDTH = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw1,
    input  logic raw2,
    output logic in1,
    output logic in2,
    output logic rise1,
    output logic fall1,
    output logic rise2,
    output logic fall2
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Channel 0 is raw1/in1, channel 1 is raw2/in2.
    logic [1:0] raw_vec;
    logic [1:0] level_vec;
    logic [1:0] rise_vec;
    logic [1:0] fall_vec;

    assign raw_vec = {raw2, raw1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic                 s1_reg;
            logic                 s2_reg;
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic [CNT_WIDTH-1:0] cnt_next;
            logic                 stable_reg;
            logic                 stable_next;
            logic                 rise_reg;
            logic                 rise_next;
            logic                 fall_reg;
            logic                 fall_next;

            // Two-flop synchronizer; only s2 is consumed downstream.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw_vec[gi];
                    s2_reg <= s1_reg;
                end
            end

            // Window counter: restarts whenever s2 agrees with the committed
            // level, commits the new level on the cycle the count is full.
            always_comb begin
                cnt_next    = CNT_ZERO;
                stable_next = stable_reg;
                rise_next   = 1'b0;
                fall_next   = 1'b0;
                if (s2_reg != stable_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        stable_next = s2_reg;
                        cnt_next    = CNT_ZERO;
                        rise_next   = s2_reg;
                        fall_next   = ~s2_reg;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
            end

            // Debounce state and edge pulses; reset aborts any window in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg    <= CNT_ZERO;
                    stable_reg <= 1'b0;
                    rise_reg   <= 1'b0;
                    fall_reg   <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    stable_reg <= stable_next;
                    rise_reg   <= rise_next;
                    fall_reg   <= fall_next;
                end
            end

            assign level_vec[gi] = stable_reg;
            assign rise_vec[gi]  = rise_reg;
            assign fall_vec[gi]  = fall_reg;
        end
    endgenerate

    assign in1   = level_vec[0];
    assign in2   = level_vec[1];
    assign rise1 = rise_vec[0];
    assign fall1 = fall_vec[0];
    assign rise2 = rise_vec[1];
    assign fall2 = fall_vec[1];

endmodule

// File: tb/tb_switch_debounce2.sv
// Testbench for switch_debounce2 with CNT_WIDTH = 4 (window of 16 cycles).
// The driver pushes the expected output vector for every clock edge into a
// queue; an independent monitor pops and compares it just after each edge.
// The reference model says: a channel's level flips at an edge when the 16
// synchronized samples seen before that edge all differ from the level.
module tb_switch_debounce2;

    localparam int CW  = 4;
    localparam int WIN = 1 << CW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw1 = 1'b0;
    logic raw2 = 1'b0;
    logic in1, in2, rise1, fall1, rise2, fall2;

    int checks = 0;
    int errors = 0;

    // Expected {in1, in2, rise1, fall1, rise2, fall2} after each edge.
    logic [5:0] exp_q[$];

    // Model state: per channel, history of raw samples taken at each edge
    // (index 0 newest), number of valid entries, and committed level.
    bit hist[2][0:WIN];
    int hist_valid[2];
    bit level_m[2];

    switch_debounce2 #(.CNT_WIDTH(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .raw1 (raw1),
        .raw2 (raw2),
        .in1  (in1),
        .in2  (in2),
        .rise1(rise1),
        .fall1(fall1),
        .rise2(rise2),
        .fall2(fall2)
    );

    always #5 clk = ~clk;

    // Reference model for one clock edge.
    task automatic model_edge(input logic rs, input logic r1, input logic r2);
        logic [1:0] r;
        logic [1:0] ri;
        logic [1:0] fa;
        bit all_diff;
        r  = {r2, r1};
        ri = 2'b00;
        fa = 2'b00;
        for (int c = 0; c < 2; c++) begin
            if (rs) begin
                level_m[c]    = 1'b0;
                hist[c][0]    = 1'b0;
                hist_valid[c] = 1;
            end else begin
                // Samples from edges u-2 .. u-17 are what s2 showed on the
                // 16 edges leading up to (and including) this one.
                all_diff = (hist_valid[c] >= WIN + 1);
                for (int i = 1; i <= WIN; i++)
                    if (hist[c][i] == level_m[c]) all_diff = 1'b0;
                if (all_diff) begin
                    level_m[c] = ~level_m[c];
                    if (level_m[c]) ri[c] = 1'b1;
                    else            fa[c] = 1'b1;
                end
                for (int i = WIN; i >= 1; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = r[c];
                if (hist_valid[c] < WIN + 1) hist_valid[c]++;
            end
        end
        exp_q.push_back({level_m[0], level_m[1], ri[0], fa[0], ri[1], fa[1]});
    endtask

    // One clock cycle of stimulus; inputs change 2 time units after the edge.
    task automatic step(input logic r1, input logic r2, input logic rs);
        raw1 = r1;
        raw2 = r2;
        rst  = rs;
        @(posedge clk);
        model_edge(rs, r1, r2);
        #2;
    endtask

    // Hold the given raw levels for len edges and note the first edge (1-based,
    // counting the first edge that samples these levels) of each event.
    task automatic run_window(input logic r1, input logic r2, input int len,
                              output int e1r, output int e1f,
                              output int e2r, output int e2f, output int enor);
        e1r = 0; e1f = 0; e2r = 0; e2f = 0; enor = 0;
        for (int n = 1; n <= len; n++) begin
            step(r1, r2, 1'b0);
            if (rise1 && e1r == 0) e1r = n;
            if (fall1 && e1f == 0) e1f = n;
            if (rise2 && e2r == 0) e2r = n;
            if (fall2 && e2f == 0) e2f = n;
            if (!(in1 || in2) && enor == 0) enor = n;
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation.
    always @(posedge clk) begin : monitor
        logic [5:0] e;
        logic [5:0] a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {in1, in2, rise1, fall1, rise2, fall2};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs at %0t: got %b, expected %b (in1 in2 rise1 fall1 rise2 fall2)",
                         $time, a, e);
            end
        end
    end

    initial begin : driver
        int e1r, e1f, e2r, e2f, enor;
        int hold[2];
        logic lvl[2];
        for (int c = 0; c < 2; c++) begin
            hist_valid[c] = 0;
            level_m[c]    = 1'b0;
        end

        // Reset held with both raws high.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        chk("reset_outputs", int'({in1, in2, rise1, fall1, rise2, fall2}), 0);
        run_window(1'b1, 1'b1, 30, e1r, e1f, e2r, e2f, enor);
        chk("reset_release_rise1_edge", e1r, 18);
        chk("reset_release_rise2_edge", e2r, 18);

        // Both released together: simultaneous falls, NOR goes high.
        run_window(1'b0, 1'b0, 30, e1r, e1f, e2r, e2f, enor);
        chk("release_fall1_edge", e1f, 18);
        chk("release_fall2_edge", e2f, 18);
        chk("release_nor_high_edge", enor, 18);

        // Clean press on channel 1 only.
        run_window(1'b1, 1'b0, 30, e1r, e1f, e2r, e2f, enor);
        chk("press_rise1_edge", e1r, 18);
        chk("press_rise2_none", e2r, 0);
        chk("press_fall2_none", e2f, 0);
        run_window(1'b0, 1'b0, 30, e1r, e1f, e2r, e2f, enor);
        chk("press_release_fall1_edge", e1f, 18);

        // 15-cycle glitch is rejected.
        run_window(1'b1, 1'b0, 15, e1r, e1f, e2r, e2f, enor);
        chk("glitch15_rise1_none", e1r, 0);
        run_window(1'b0, 1'b0, 30, e1r, e1f, e2r, e2f, enor);
        chk("glitch15_after_rise1_none", e1r, 0);
        chk("glitch15_after_fall1_none", e1f, 0);

        // 16-cycle pulse qualifies: rise on edge 18 counted from its start.
        run_window(1'b1, 1'b0, 16, e1r, e1f, e2r, e2f, enor);
        chk("pulse16_rise1_early_none", e1r, 0);
        run_window(1'b0, 1'b0, 30, e1r, e1f, e2r, e2f, enor);
        chk("pulse16_rise1_edge", e1r, 2);
        chk("pulse16_fall1_edge", e1f, 18);

        // Bouncing raw2 then a clean hold.
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 3; i++) step(1'b0, (b % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
        run_window(1'b0, 1'b1, 30, e1r, e1f, e2r, e2f, enor);
        chk("bounce_rise2_edge", e2r, 18);
        run_window(1'b0, 1'b0, 30, e1r, e1f, e2r, e2f, enor);
        chk("bounce_release_fall2_edge", e2f, 18);

        // Reset in the middle of a qualification window.
        e1r = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (rise1) e1r = 1;
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (rise1) e1r = 1;
        end
        chk("midreset_no_early_rise1", e1r, 0);
        run_window(1'b1, 1'b0, 30, e1r, e1f, e2r, e2f, enor);
        chk("midreset_rise1_edge", e1r, 18);

        // Randomized bouncing on both channels with occasional resets.
        lvl[0] = 1'b1; lvl[1] = 1'b0;
        hold[0] = 1;   hold[1] = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 2; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    lvl[c]  = ~lvl[c];
                    hold[c] = $urandom_range(1, 24);
                end
            end
            step(lvl[0], lvl[1], ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 20; i++) step(lvl[0], lvl[1], 1'b0);

        #5;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
